// File: rtl/cache_mem_arbiter.sv
// Two-port line arbiter between a data cache and an instruction cache sharing
// one memory port. One line transaction is outstanding at a time. Simultaneous
// requests alternate round-robin. A requester that is killed mid-flight lets the
// memory transaction finish, but does not receive an ack.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // dcache side
    input  logic              dcache2arb_req_i,
    input  logic              dcache2arb_wr_i,
    input  logic [ADDR_W-1:0] dcache2arb_addr_i,
    input  logic [LINE_W-1:0] dcache2arb_wdata_i,
    input  logic              dcache_kill_i,
    output logic              arb2dcache_ack_o,
    output logic [LINE_W-1:0] arb2dcache_rdata_o,
    // icache side
    input  logic              icache2arb_req_i,
    input  logic [ADDR_W-1:0] icache2arb_addr_i,
    input  logic              icache_kill_i,
    output logic              arb2icache_ack_o,
    output logic [LINE_W-1:0] arb2icache_rdata_o,
    // memory side
    output logic              arb2mem_req_o,
    output logic              arb2mem_wr_o,
    output logic [ADDR_W-1:0] arb2mem_addr_o,
    output logic [LINE_W-1:0] arb2mem_wdata_o,
    input  logic              mem2arb_ack_i,
    input  logic [LINE_W-1:0] mem2arb_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    state_t              state_r;
    logic                owner_r;
    logic                last_grant_r;
    logic                killed_r;
    logic                mem_req_r;
    logic                mem_wr_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [LINE_W-1:0]   mem_wdata_r;

    logic                d_elig_s;
    logic                i_elig_s;
    logic                grant_vld_s;
    logic                grant_sel_s;
    logic                owner_kill_s;
    logic                mem_done_s;
    logic                d_ack_s;
    logic                i_ack_s;

    // Eligibility and round-robin selection among requests seen in IDLE.
    always_comb begin
        d_elig_s    = dcache2arb_req_i & ~dcache_kill_i;
        i_elig_s    = icache2arb_req_i & ~icache_kill_i;
        grant_vld_s = d_elig_s | i_elig_s;
        if (d_elig_s && i_elig_s) begin
            if (last_grant_r == OWN_D) begin
                grant_sel_s = OWN_I;
            end else begin
                grant_sel_s = OWN_D;
            end
        end else if (i_elig_s) begin
            grant_sel_s = OWN_I;
        end else begin
            grant_sel_s = OWN_D;
        end
    end

    // Completion decode: the ack goes straight to the current owner unless it was killed.
    always_comb begin
        if (owner_r == OWN_I) begin
            owner_kill_s = icache_kill_i;
        end else begin
            owner_kill_s = dcache_kill_i;
        end
        mem_done_s = (state_r == ST_BUSY) && mem2arb_ack_i;
        d_ack_s    = mem_done_s && !killed_r && (owner_r == OWN_D);
        i_ack_s    = mem_done_s && !killed_r && (owner_r == OWN_I);
    end

    // Transaction FSM. The memory request registers are loaded on grant and held through BUSY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_D;
            last_grant_r <= OWN_I;
            killed_r     <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        state_r      <= ST_BUSY;
                        owner_r      <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        mem_req_r    <= 1'b1;
                        if (grant_sel_s == OWN_I) begin
                            mem_wr_r    <= 1'b0;
                            mem_addr_r  <= icache2arb_addr_i;
                            mem_wdata_r <= {LINE_W{1'b0}};
                        end else begin
                            mem_wr_r    <= dcache2arb_wr_i;
                            mem_addr_r  <= dcache2arb_addr_i;
                            mem_wdata_r <= dcache2arb_wdata_i;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (owner_kill_s) begin
                        killed_r <= 1'b1;
                    end else begin
                        killed_r <= killed_r;
                    end
                    if (mem2arb_ack_i) begin
                        state_r   <= ST_DONE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // One dead cycle so a requester dropping req after its ack is never regranted.
                    state_r  <= ST_IDLE;
                    killed_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    killed_r  <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign arb2mem_req_o      = mem_req_r;
    assign arb2mem_wr_o       = mem_wr_r;
    assign arb2mem_addr_o     = mem_addr_r;
    assign arb2mem_wdata_o    = mem_wdata_r;
    assign arb2dcache_ack_o   = d_ack_s;
    assign arb2icache_ack_o   = i_ack_s;
    assign arb2dcache_rdata_o = mem2arb_rdata_i;
    assign arb2icache_rdata_o = mem2arb_rdata_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter. The driver pushes expected acks,
// expected memory transactions and timed probes. A monitor on the falling edge
// pops these and compares them against the DUT outputs.
module tb_cache_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int MEM_LAT = 4;

    localparam int K_MREQ = 0;
    localparam int K_DACK = 1;
    localparam int K_IACK = 2;
    localparam int K_ZERO = 3;
    localparam int K_END  = 4;
    localparam int K_MWR  = 5;

    typedef struct {
        logic              port;
        logic [LINE_W-1:0] rdata;
    } ack_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [LINE_W-1:0] wdata;
    } mem_t;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } probe_t;

    logic              clk;
    logic              rst_n;
    logic              d_req, d_wr, d_kill, d_ack;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata, d_rdata;
    logic              i_req, i_kill, i_ack;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              m_req, m_wr, m_ack;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata, m_rdata;

    ack_t              exp_ack[$];
    mem_t              exp_mem[$];
    probe_t            probes[$];
    logic [LINE_W-1:0] rd_q[$];

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int mem_cnt = 0;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .dcache2arb_req_i   (d_req),
        .dcache2arb_wr_i    (d_wr),
        .dcache2arb_addr_i  (d_addr),
        .dcache2arb_wdata_i (d_wdata),
        .dcache_kill_i      (d_kill),
        .arb2dcache_ack_o   (d_ack),
        .arb2dcache_rdata_o (d_rdata),
        .icache2arb_req_i   (i_req),
        .icache2arb_addr_i  (i_addr),
        .icache_kill_i      (i_kill),
        .arb2icache_ack_o   (i_ack),
        .arb2icache_rdata_o (i_rdata),
        .arb2mem_req_o      (m_req),
        .arb2mem_wr_o       (m_wr),
        .arb2mem_addr_o     (m_addr),
        .arb2mem_wdata_o    (m_wdata),
        .mem2arb_ack_i      (m_ack),
        .mem2arb_rdata_i    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboards and timed probes, sampled on the falling edge.
    initial begin : monitor
        ack_t   a;
        mem_t   m;
        mem_t   cur_m;
        probe_t p;
        logic   prev_req;
        prev_req    = 1'b0;
        cur_m.addr  = '0;
        cur_m.wr    = 1'b0;
        cur_m.wdata = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (d_ack && i_ack) begin
                chk("dual_ack", LINE_W'({d_ack, i_ack}), LINE_W'(2'b00));
            end else if (d_ack || i_ack) begin
                if (exp_ack.size() == 0) begin
                    chk("unexpected_ack", LINE_W'({d_ack, i_ack}), LINE_W'(2'b00));
                end else begin
                    a = exp_ack.pop_front();
                    chk("ack_port", LINE_W'(i_ack), LINE_W'(a.port));
                    chk("ack_rdata", i_ack ? i_rdata : d_rdata, a.rdata);
                end
            end
            if (m_req && !prev_req) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req", LINE_W'(m_req), LINE_W'(1'b0));
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", LINE_W'(m_addr), LINE_W'(m.addr));
                    chk("mem_wr", LINE_W'(m_wr), LINE_W'(m.wr));
                    chk("mem_wdata", m_wdata, m.wdata);
                    cur_m = m;
                end
            end else if (m_req) begin
                chk("mem_stable", LINE_W'(m_addr == cur_m.addr && m_wr == cur_m.wr && m_wdata == cur_m.wdata),
                    LINE_W'(1'b1));
            end
            prev_req = m_req;
            while (probes.size() > 0 && probes[0].cyc <= cyc) begin
                p = probes.pop_front();
                case (p.kind)
                    K_MREQ: chk($sformatf("mem_req@%0d", p.cyc), LINE_W'(m_req), LINE_W'(p.val));
                    K_DACK: chk($sformatf("dcache_ack@%0d", p.cyc), LINE_W'(d_ack), LINE_W'(p.val));
                    K_IACK: chk($sformatf("icache_ack@%0d", p.cyc), LINE_W'(i_ack), LINE_W'(p.val));
                    K_MWR:  chk($sformatf("mem_wr@%0d", p.cyc), LINE_W'(m_wr), LINE_W'(p.val));
                    K_ZERO: chk($sformatf("outputs_zero@%0d", p.cyc),
                                LINE_W'({m_req, m_wr, |m_addr, |m_wdata, d_ack, i_ack}), LINE_W'(6'b0));
                    K_END:  chk("queues_drained", LINE_W'(exp_ack.size() + exp_mem.size() + rd_q.size()),
                                LINE_W'(0));
                    default: chk("bad_probe_kind", LINE_W'(p.kind), LINE_W'(0));
                endcase
            end
        end
    end

    function automatic int now_c();
        return cyc + 1;
    endfunction

    task automatic probe(input int c, input int k, input logic v);
        probe_t p;
        int     i;
        p.cyc  = c;
        p.kind = k;
        p.val  = v;
        i = 0;
        while (i < probes.size() && probes[i].cyc <= c) i++;
        probes.insert(i, p);
    endtask

    // One clock: requesters drop req after their ack, kills self-clear, memory model answers.
    task automatic step();
        logic d_seen, i_seen;
        @(negedge clk);
        d_seen = d_ack;
        i_seen = i_ack;
        @(posedge clk);
        #1;
        if (d_seen) begin
            d_req = 1'b0;
            d_wr  = 1'b0;
        end
        if (i_seen) i_req = 1'b0;
        d_kill = 1'b0;
        i_kill = 1'b0;
        m_ack  = 1'b0;
        if (!rst_n) begin
            mem_cnt = 0;
        end else if (m_req) begin
            mem_cnt++;
            if (mem_cnt == MEM_LAT) begin
                m_ack = 1'b1;
                if (rd_q.size() > 0) m_rdata = rd_q.pop_front();
                mem_cnt = 0;
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic d_issue(input logic [ADDR_W-1:0] a, input logic w, input logic [LINE_W-1:0] wd,
                           input logic [LINE_W-1:0] rd, input bit push_rd, input bit push_ack);
        d_req   = 1'b1;
        d_wr    = w;
        d_addr  = a;
        d_wdata = wd;
        exp_mem.push_back('{addr: a, wr: w, wdata: wd});
        if (push_rd) rd_q.push_back(rd);
        if (push_ack) exp_ack.push_back('{port: 1'b0, rdata: rd});
    endtask

    task automatic i_issue(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] rd,
                           input bit push_rd, input bit push_ack);
        i_req  = 1'b1;
        i_addr = a;
        exp_mem.push_back('{addr: a, wr: 1'b0, wdata: {LINE_W{1'b0}}});
        if (push_rd) rd_q.push_back(rd);
        if (push_ack) exp_ack.push_back('{port: 1'b1, rdata: rd});
    endtask

    // Driver: directed scenarios.
    initial begin : driver
        int c;
        rst_n = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_kill = 1'b0;
        i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
        m_ack = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        probe(now_c(), K_ZERO, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Single dcache fill with exact cycle timing.
        c = now_c();
        d_issue(32'h8000_0040, 1'b0, {LINE_W{1'b0}}, {16{8'hA5}}, 1'b1, 1'b1);
        probe(c, K_MREQ, 1'b0);
        for (int k = 1; k <= 4; k++) probe(c + k, K_MREQ, 1'b1);
        probe(c + 3, K_DACK, 1'b0);
        probe(c + 4, K_DACK, 1'b1);
        for (int k = 5; k <= 7; k++) probe(c + k, K_MREQ, 1'b0);
        steps(9);

        // Simultaneous requests after reset: dcache first, then icache, then dcache wins next tie.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        c = now_c();
        d_issue(32'h0000_1000, 1'b0, {LINE_W{1'b0}}, {4{32'hD000_0001}}, 1'b1, 1'b1);
        i_issue(32'h0000_2000, {4{32'h1000_0002}}, 1'b1, 1'b1);
        probe(c + 4, K_DACK, 1'b1);
        probe(c + 4, K_IACK, 1'b0);
        probe(c + 5, K_MREQ, 1'b0);
        probe(c + 6, K_MREQ, 1'b0);
        probe(c + 7, K_MREQ, 1'b1);
        probe(c + 10, K_IACK, 1'b1);
        steps(12);
        c = now_c();
        d_issue(32'h0000_1040, 1'b0, {LINE_W{1'b0}}, {4{32'hD000_0003}}, 1'b1, 1'b1);
        i_issue(32'h0000_2040, {4{32'h1000_0004}}, 1'b1, 1'b1);
        probe(c + 4, K_DACK, 1'b1);
        probe(c + 4, K_IACK, 1'b0);
        probe(c + 10, K_IACK, 1'b1);
        steps(12);

        // Writeback, an icache request arriving in BUSY, and a non-owner kill.
        c = now_c();
        d_issue(32'h0000_5000, 1'b1, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                {LINE_W{1'b0}}, 1'b1, 1'b1);
        probe(c + 1, K_MWR, 1'b1);
        probe(c + 4, K_DACK, 1'b1);
        steps(2);
        i_issue(32'h0000_6000, {4{32'h1000_0005}}, 1'b1, 1'b1);
        step();
        i_kill = 1'b1;
        step();
        probe(c + 5, K_MREQ, 1'b0);
        probe(c + 7, K_MREQ, 1'b1);
        probe(c + 7, K_MWR, 1'b0);
        probe(c + 10, K_IACK, 1'b1);
        steps(9);

        // Owner kill mid-transaction: memory still completes, icache gets no ack.
        c = now_c();
        i_issue(32'h0000_7000, {4{32'h1000_0006}}, 1'b1, 1'b0);
        steps(2);
        i_kill = 1'b1;
        i_req  = 1'b0;
        step();
        d_issue(32'h0000_8000, 1'b0, {LINE_W{1'b0}}, {4{32'hD000_0007}}, 1'b1, 1'b1);
        probe(c + 3, K_MREQ, 1'b1);
        probe(c + 4, K_MREQ, 1'b1);
        probe(c + 4, K_IACK, 1'b0);
        probe(c + 10, K_DACK, 1'b1);
        steps(9);

        // Reset in BUSY: outputs clear at once and no ack follows.
        c = now_c();
        d_issue(32'h0000_9000, 1'b1, {4{32'hCAFE_F00D}}, {LINE_W{1'b0}}, 1'b0, 1'b0);
        steps(2);
        rst_n = 1'b0;
        d_req = 1'b0;
        d_wr  = 1'b0;
        probe(c + 2, K_ZERO, 1'b0);
        steps(2);
        rst_n = 1'b1;
        probe(c + 5, K_MREQ, 1'b0);
        probe(c + 6, K_MREQ, 1'b0);
        steps(6);

        // Stray memory ack in IDLE is ignored, and the next fill runs normally.
        c = now_c();
        m_ack   = 1'b1;
        m_rdata = {LINE_W{1'b1}};
        probe(c, K_DACK, 1'b0);
        probe(c, K_IACK, 1'b0);
        probe(c + 1, K_MREQ, 1'b0);
        probe(c + 2, K_MREQ, 1'b0);
        steps(3);
        c = now_c();
        d_issue(32'h0000_A000, 1'b0, {LINE_W{1'b0}}, {4{32'hD000_0008}}, 1'b1, 1'b1);
        probe(c + 1, K_MREQ, 1'b1);
        probe(c + 4, K_DACK, 1'b1);
        steps(8);

        probe(now_c(), K_END, 1'b0);
        steps(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL provide parameters: ADDR_W, default 32, address width; LINE_W, default 128, cache line width in bits.
REQ-002 SHALL have ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- dcache2arb_req_i  in  1  dcache line request, held high until its ack.
- dcache2arb_wr_i  in  1  1 = line writeback, 0 = line fill.
- dcache2arb_addr_i  in  ADDR_W  dcache line address.
- dcache2arb_wdata_i  in  LINE_W  writeback data.
- dcache_kill_i  in  1  abandon the dcache request.
- arb2dcache_ack_o  out  1  one-cycle completion pulse to dcache.
- arb2dcache_rdata_o  out  LINE_W  fill data, valid with ack.
- icache2arb_req_i  in  1  icache line fill request, held until ack.
- icache2arb_addr_i  in  ADDR_W  icache line address.
- icache_kill_i  in  1  abandon the icache request.
- arb2icache_ack_o  out  1  one-cycle completion pulse to icache.
- arb2icache_rdata_o  out  LINE_W  fill data, valid with ack.
- arb2mem_req_o  out  1  memory request.
- arb2mem_wr_o  out  1  memory write enable.
- arb2mem_addr_o  out  ADDR_W  memory address.
- arb2mem_wdata_o  out  LINE_W  memory write data.
- mem2arb_ack_i  in  1  memory completion pulse.
- mem2arb_rdata_i  in  LINE_W  memory read data, valid with ack.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY and DONE, with a registered owner (D or I), a last_grant register and a killed flag.
REQ-004 In IDLE, a request is eligible only if its req is 1 and its kill is 0 in that cycle.
REQ-005 With a single eligible request, SHALL grant it; with both eligible, SHALL grant the one not equal to last_grant (round-robin).
REQ-006 On a grant, at the next edge: state becomes BUSY, owner and last_grant are set, and address, write data and wr are latched into the arb2mem_* registers (icache wr forced 0).
REQ-007 arb2mem_req_o SHALL be 1 exactly while in BUSY; addr, wdata and wr SHALL stay stable for the whole of BUSY.
REQ-008 Request-to-memory latency SHALL be 1 cycle from the IDLE grant cycle.
REQ-009 In BUSY with mem2arb_ack_i = 1:
- owner ack SHALL be mem2arb_ack_i AND NOT killed (combinational, same cycle).
- owner rdata SHALL pass mem2arb_rdata_i through.
- the next state SHALL be DONE.
REQ-010 The non-owner ack SHALL always be 0; rdata outputs SHALL be mem2arb_rdata_i (don't-care when ack is 0).
REQ-011 DONE SHALL last exactly one cycle, then go to IDLE, and SHALL make no grant, so a requester dropping req the cycle after its ack is never regranted.
REQ-012 Owner kill in BUSY SHALL set killed. The memory transaction SHALL still run to mem ack (no abort) and the owner ack SHALL be suppressed. killed SHALL clear on entry to IDLE.
REQ-013 Non-owner kill during BUSY or DONE SHALL have no effect on the current transaction.
REQ-014 A request arriving in BUSY or DONE SHALL wait; no request is lost while req is held.
REQ-015 Worst-case wait for a continuously asserted request SHALL be one full transaction of the other requester.
REQ-016 A mem ack outside BUSY SHALL be ignored.

Reset
REQ-017 On rst_ni low, asynchronously: state = IDLE, arb2mem_req_o = 0, arb2mem_wr_o = 0, arb2mem_addr_o = 0, arb2mem_wdata_o = 0, both acks = 0, killed = 0, owner = D, last_grant = I (first tie goes to dcache).
REQ-018 Reset during BUSY SHALL drop arb2mem_req_o immediately; no ack SHALL follow after release.

Verification
REQ-019 Single dcache fill:
- stimulus: dcache req at cycle 0, addr 0x8000_0040, wr = 0; mem ack at cycle 4 with rdata 0xA5..A5.
- required: mem_req 1 in cycles 1-4; dcache ack and rdata 0xA5..A5 in cycle 4; IDLE in cycle 6.
REQ-020 Simultaneous requests after reset:
- stimulus: dcache and icache req both held from cycle 0.
- required: dcache served first; icache granted in the first IDLE after dcache's DONE; next tie goes to dcache again.
REQ-021 Dcache writeback:
- stimulus: dcache req with wr = 1, wdata 0x1122..FF.
- required: arb2mem_wr_o = 1 and arb2mem_wdata_o = 0x1122..FF, held stable until mem ack.
REQ-022 Kill mid-transaction:
- stimulus: icache_kill_i pulsed in BUSY with icache as owner.
- required: mem_req stays 1 until mem ack; arb2icache_ack_o stays 0; a dcache request then proceeds normally.
REQ-023 Reset mid-operation and stray acks:
- stimulus: rst_ni low in BUSY; separately, mem ack in IDLE.
- required: all outputs 0 at once and no later ack; the IDLE mem ack causes no state change and no ack.
